// File: rtl/move_link_pkg.sv
// Shared types and constants for the move_link frame codec.
package move_link_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Payload carries the move word plus the colour bit, rounded up to whole bytes.
  function automatic int calc_nb(input int moveW);
    return (moveW + 8) / 8;
  endfunction

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_PAYLOAD,
    RX_CHECK
  } rx_state_e;

endpackage

// File: rtl/move_link_if.sv
// Bundle of the game-controller and UART byte signals around move_link.
interface move_link_if #(
  parameter int MOVE_W = 22
);

  logic [MOVE_W-1:0] move_in;
  logic              color_in;
  logic              start_transmit;
  logic              tx_busy;
  logic [7:0]        tx_byte;
  logic              send;
  logic              tx_done;
  logic [7:0]        rx_byte;
  logic              rx_finish;
  logic [MOVE_W-1:0] move_out;
  logic              color;
  logic              end_receive;
  logic              rx_error;

  modport slave (
    input  move_in, color_in, start_transmit, tx_done, rx_byte, rx_finish,
    output tx_busy, tx_byte, send, move_out, color, end_receive, rx_error
  );

  modport master (
    output move_in, color_in, start_transmit, tx_done, rx_byte, rx_finish,
    input  tx_busy, tx_byte, send, move_out, color, end_receive, rx_error
  );

endinterface

// File: rtl/move_frame_rx.sv
// Receive side: hunts for SYNC, collects payload, verifies the XOR checksum
// and enforces an inter-byte timeout while inside a frame.
module move_frame_rx
  import move_link_pkg::*;
#(
  parameter int         MOVE_W      = 22,
  parameter logic [7:0] SYNC        = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rxByte_i,
  input  logic              rxFinish_i,
  output logic [MOVE_W-1:0] moveOut_o,
  output logic              color_o,
  output logic              endReceive_o,
  output logic              rxError_o
);

  localparam int NB = calc_nb(MOVE_W);
  localparam int PW = NB * 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  rx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [PW-1:0]     shift_q, shift_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [MOVE_W-1:0] move_q, move_d;
  logic              color_q, color_d;
  logic              endRx_q, endRx_d;
  logic              rxErr_q, rxErr_d;
  logic              timedOut;

  // A byte arriving in the same cycle as expiry wins, so expiry needs silence.
  assign timedOut = !rxFinish_i && (timer_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    shift_d = shift_q;
    timer_d = timer_q;
    move_d  = move_q;
    color_d = color_q;
    endRx_d = 1'b0;
    rxErr_d = 1'b0;
    case (state_q)
      RX_HUNT: begin
        timer_d = '0;
        if (rxFinish_i && rxByte_i == SYNC) begin
          cnt_d   = '0;
          chk_d   = '0;
          state_d = RX_PAYLOAD;
        end
      end
      RX_PAYLOAD: begin
        if (rxFinish_i) begin
          timer_d = '0;
          shift_d = PW'({shift_q, rxByte_i});
          chk_d   = chk_q ^ rxByte_i;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(NB - 1)) begin
            state_d = RX_CHECK;
          end
        end else if (timedOut) begin
          timer_d = '0;
          rxErr_d = 1'b1;
          state_d = RX_HUNT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RX_CHECK: begin
        if (rxFinish_i) begin
          timer_d = '0;
          state_d = RX_HUNT;
          if (rxByte_i == chk_q) begin
            move_d  = shift_q[MOVE_W-1:0];
            color_d = shift_q[MOVE_W];
            endRx_d = 1'b1;
          end else begin
            rxErr_d = 1'b1;
          end
        end else if (timedOut) begin
          timer_d = '0;
          rxErr_d = 1'b1;
          state_d = RX_HUNT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = RX_HUNT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RX_HUNT;
      cnt_q   <= '0;
      chk_q   <= '0;
      shift_q <= '0;
      timer_q <= '0;
      move_q  <= '0;
      color_q <= 1'b0;
      endRx_q <= 1'b0;
      rxErr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      shift_q <= shift_d;
      timer_q <= timer_d;
      move_q  <= move_d;
      color_q <= color_d;
      endRx_q <= endRx_d;
      rxErr_q <= rxErr_d;
    end
  end

  assign moveOut_o    = move_q;
  assign color_o      = color_q;
  assign endReceive_o = endRx_q;
  assign rxError_o    = rxErr_q;

endmodule

// File: rtl/move_link.sv
// Frame codec top: transmit FSM serialising {colour, move} as SYNC, payload,
// checksum; the independent receive path lives in move_frame_rx.
module move_link
  import move_link_pkg::*;
#(
  parameter int         MOVE_W      = 22,
  parameter logic [7:0] SYNC        = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  move_link_if.slave bus
);

  localparam int NB   = calc_nb(MOVE_W);
  localparam int PW   = NB * 8;
  localparam int IDXW = $clog2(NB + 2);

  tx_state_e       txState_q, txState_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic [7:0]      txByte_q, txByte_d;
  logic            send_q, send_d;
  logic [7:0]      chkByte;
  logic [7:0]      payByte;
  logic [7:0]      frameByte;

  // Frame index 0 is SYNC, 1..NB the payload MSB first, NB+1 the checksum.
  always_comb begin
    chkByte = '0;
    payByte = '0;
    for (int i = 0; i < NB; i++) begin
      chkByte = chkByte ^ payload_q[PW-1-8*i -: 8];
      if (idx_q == IDXW'(i + 1)) begin
        payByte = payload_q[PW-1-8*i -: 8];
      end
    end
    if (idx_q == '0) begin
      frameByte = SYNC;
    end else if (idx_q == IDXW'(NB + 1)) begin
      frameByte = chkByte;
    end else begin
      frameByte = payByte;
    end
  end

  always_comb begin
    txState_d = txState_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    txByte_d  = txByte_q;
    send_d    = 1'b0;
    case (txState_q)
      TX_IDLE: begin
        if (bus.start_transmit) begin
          payload_d = PW'({bus.color_in, bus.move_in});
          idx_d     = '0;
          txState_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        send_d    = 1'b1;
        txByte_d  = frameByte;
        txState_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (bus.tx_done) begin
          if (idx_q == IDXW'(NB + 1)) begin
            txState_d = TX_IDLE;
          end else begin
            idx_d     = idx_q + 1'b1;
            txState_d = TX_LOAD;
          end
        end
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txState_q <= TX_IDLE;
      idx_q     <= '0;
      payload_q <= '0;
      txByte_q  <= '0;
      send_q    <= 1'b0;
    end else begin
      txState_q <= txState_d;
      idx_q     <= idx_d;
      payload_q <= payload_d;
      txByte_q  <= txByte_d;
      send_q    <= send_d;
    end
  end

  assign bus.tx_busy = (txState_q != TX_IDLE);
  assign bus.tx_byte = txByte_q;
  assign bus.send    = send_q;

  move_frame_rx #(
    .MOVE_W     (MOVE_W),
    .SYNC       (SYNC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) uRx (
    .clock       (clock),
    .reset       (reset),
    .rxByte_i    (bus.rx_byte),
    .rxFinish_i  (bus.rx_finish),
    .moveOut_o   (bus.move_out),
    .color_o     (bus.color),
    .endReceive_o(bus.end_receive),
    .rxError_o   (bus.rx_error)
  );

endmodule
